// File: rtl/rf_write_queue.sv
// In-order writeback queue for a single-write-port register file: merges ALU and
// load-return writes, drains one per cycle, and forwards the newest pending value.
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_wr_valid,
  input  logic [AW-1:0]            alu_wr_addr,
  input  logic [DW-1:0]            alu_wr_data,
  output logic                     alu_wr_ready,
  input  logic                     mem_wr_valid,
  input  logic [AW-1:0]            mem_wr_addr,
  input  logic [DW-1:0]            mem_wr_data,
  output logic                     mem_wr_ready,
  output logic                     rf_wr,
  output logic [AW-1:0]            rf_a3,
  output logic [DW-1:0]            rf_wd,
  input  logic [AW-1:0]            fwd_a1,
  input  logic [AW-1:0]            fwd_a2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_d1,
  output logic [DW-1:0]            fwd_d2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          pop;
  logic          mem_push, alu_push;
  logic          mem_nonzero;
  logic [CW-1:0] free;
  logic [CW-1:0] alu_need;
  logic [PW-1:0] alu_slot;

  // The head entry drains every cycle the queue is non-empty, so its slot is
  // already reusable by a push on the same edge.
  assign pop          = (count_q != '0);
  assign free         = DEPTH_C - count_q + CW'(pop);
  assign mem_nonzero  = mem_wr_valid && (mem_wr_addr != '0);
  assign alu_need     = CW'(1) + CW'(mem_nonzero);
  assign mem_wr_ready = (free >= CW'(1));
  assign alu_wr_ready = (free >= alu_need);

  // Writes to r0 complete the handshake but are dropped here.
  assign mem_push = mem_wr_valid && mem_wr_ready && (mem_wr_addr != '0);
  assign alu_push = alu_wr_valid && alu_wr_ready && (alu_wr_addr != '0);
  assign alu_slot = tail_q + PW'(mem_push);

  assign head_d  = head_q + PW'(pop);
  assign tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
  assign count_d = count_q - CW'(pop) + CW'(mem_push) + CW'(alu_push);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Load return is the older instruction, so it takes the lower slot.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      addr_q[tail_q] <= mem_wr_addr;
      data_q[tail_q] <= mem_wr_data;
    end
    if (alu_push) begin
      addr_q[alu_slot] <= alu_wr_addr;
      data_q[alu_slot] <= alu_wr_data;
    end
  end

  assign rf_wr = pop;
  assign rf_a3 = pop ? addr_q[head_q] : '0;
  assign rf_wd = pop ? data_q[head_q] : '0;
  assign count = count_q;

  // Scan oldest to newest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit1 = 1'b0;
    fwd_hit2 = 1'b0;
    fwd_d1   = '0;
    fwd_d2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((fwd_a1 != '0) && (addr_q[idx] == fwd_a1)) begin
          fwd_hit1 = 1'b1;
          fwd_d1   = data_q[idx];
        end
        if ((fwd_a2 != '0) && (addr_q[idx] == fwd_a2)) begin
          fwd_hit2 = 1'b1;
          fwd_d2   = data_q[idx];
        end
      end
    end
  end

endmodule
